rc4_ksa_engine: RTL and testbench

Parametrised RC4 key-scheduling engine for the RC4 datapath. It optionally fills the 256-byte S-box RAM with the identity permutation, then runs the full KSA scramble against a key of `KEY_BYTES` bytes. It drives one single-port synchronous S-box RAM and reports completion with a start/busy/done handshake. The key-stream generator downstream starts once `done` pulses.

---
 rtl/rc4_pkg.sv | 19 +
 rtl/rc4_key_sel.sv | 56 +++++
 rtl/rc4_ksa_engine.sv | 138 +++++++++++++
 tb/tb_rc4_ksa_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling datapath.
package rc4_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned SBOX_DEPTH = 256;

   typedef enum logic [3:0] {
      StIdle,
      StInit,
      StRdI,
      StLdI,
      StRdJ,
      StLdJ,
      StWrJ,
      StWrI,
      StDone
   } ksa_state_t;

endpackage

// File: rtl/rc4_key_sel.sv
// Latched key register plus the key-byte index k; presents key[k] to the KSA datapath.
module rc4_key_sel
   import rc4_pkg::*;
#(
   parameter int unsigned KEY_BYTES = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load_i,
   input  logic                          adv_i,
   input  logic                          clr_i,
   input  logic [BYTE_W*KEY_BYTES-1:0]   key_i,
   output logic [BYTE_W-1:0]             key_byte_o
);

   localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [KW-1:0] KLast = KW'(KEY_BYTES - 1);

   logic [BYTE_W*KEY_BYTES-1:0] key_q, key_d;
   logic [KW-1:0]               k_q, k_d;

   always_comb begin
      key_d = key_q;
      k_d   = k_q;
      if (load_i) begin
         key_d = key_i;
      end
      if (clr_i) begin
         k_d = '0;
      end else if (adv_i) begin
         // Compare-and-wrap avoids a modulo divider for non-power-of-two key lengths.
         k_d = (k_q == KLast) ? '0 : k_q + KW'(1);
      end
   end

   // Byte 0 sits in the most-significant byte of the key vector.
   always_comb begin
      key_byte_o = '0;
      for (int unsigned n = 0; n < KEY_BYTES; n++) begin
         if (k_q == KW'(n)) begin
            key_byte_o = key_q[BYTE_W*(KEY_BYTES-1-n) +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_q <= '0;
         k_q   <= '0;
      end else begin
         key_q <= key_d;
         k_q   <= k_d;
      end
   end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill, then the 256-step KSA scramble
// over a single-port synchronous S-box RAM, with a start/busy/done handshake.
module rc4_ksa_engine
   import rc4_pkg::*;
#(
   parameter int unsigned KEY_BYTES = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          init_en,
   input  logic [BYTE_W*KEY_BYTES-1:0]   key,
   output logic [BYTE_W-1:0]             mem_addr,
   output logic [BYTE_W-1:0]             mem_wrdata,
   output logic                          mem_wren,
   input  logic [BYTE_W-1:0]             mem_rddata,
   output logic                          busy,
   output logic                          done
);

   localparam logic [BYTE_W-1:0] ILast = BYTE_W'(SBOX_DEPTH - 1);

   ksa_state_t        state_q, state_d;
   logic [BYTE_W-1:0] i_q, i_d;
   logic [BYTE_W-1:0] j_q, j_d;
   logic [BYTE_W-1:0] si_q, si_d;
   logic [BYTE_W-1:0] sj_q, sj_d;

   logic              key_load;
   logic              k_adv;
   logic              k_clr;
   logic [BYTE_W-1:0] key_byte;

   rc4_key_sel #(
      .KEY_BYTES (KEY_BYTES)
   ) u_key_sel (
      .clk        (clk),
      .reset      (reset),
      .load_i     (key_load),
      .adv_i      (k_adv),
      .clr_i      (k_clr),
      .key_i      (key),
      .key_byte_o (key_byte)
   );

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      si_d     = si_q;
      sj_d     = sj_q;
      key_load = 1'b0;
      k_adv    = 1'b0;
      k_clr    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               key_load = 1'b1;
               k_clr    = 1'b1;
               i_d      = '0;
               j_d      = '0;
               state_d  = init_en ? StInit : StRdI;
            end
         end
         StInit: begin
            i_d = i_q + 8'd1;
            if (i_q == ILast) begin
               state_d = StRdI;
            end
         end
         StRdI: state_d = StLdI;
         StLdI: begin
            si_d    = mem_rddata;
            j_d     = j_q + mem_rddata + key_byte;
            state_d = StRdJ;
         end
         StRdJ: state_d = StLdJ;
         StLdJ: begin
            sj_d    = mem_rddata;
            state_d = StWrJ;
         end
         StWrJ: state_d = StWrI;
         StWrI: begin
            k_adv   = 1'b1;
            i_d     = i_q + 8'd1;
            state_d = (i_q == ILast) ? StDone : StRdI;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs: decoded from registered state and counters only.
   always_comb begin
      mem_addr   = '0;
      mem_wrdata = '0;
      mem_wren   = 1'b0;
      busy       = (state_q != StIdle);
      done       = (state_q == StDone);
      unique case (state_q)
         StInit: begin
            mem_addr   = i_q;
            mem_wrdata = i_q;
            mem_wren   = 1'b1;
         end
         StRdI, StLdI: mem_addr = i_q;
         StRdJ, StLdJ: mem_addr = j_q;
         StWrJ: begin
            mem_addr   = j_q;
            mem_wrdata = si_q;
            mem_wren   = 1'b1;
         end
         StWrI: begin
            mem_addr   = i_q;
            mem_wrdata = sj_q;
            mem_wren   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
      end
   end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: four key-length builds, each on its own behavioural S-box RAM,
// checked against a plain software RC4 KSA model.
module tb_rc4_ksa_engine;

   localparam int KB [4] = '{3, 5, 1, 256};

   logic          clk = 1'b0;
   logic          reset;
   logic [2047:0] key_all;
   logic          start_s [4];
   logic          init_s  [4];
   logic          pre_s   [4];
   logic [7:0]    addr_s  [4];
   logic [7:0]    wd_s    [4];
   logic [7:0]    rd_s    [4];
   logic          wren_s  [4];
   logic          busy_s  [4];
   logic          done_s  [4];
   logic [7:0]    ram     [4][256];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rc4_ksa_engine #(.KEY_BYTES(3)) dut3 (
      .clk(clk), .reset(reset), .start(start_s[0]), .init_en(init_s[0]), .key(key_all[23:0]),
      .mem_addr(addr_s[0]), .mem_wrdata(wd_s[0]), .mem_wren(wren_s[0]),
      .mem_rddata(rd_s[0]), .busy(busy_s[0]), .done(done_s[0]));

   rc4_ksa_engine #(.KEY_BYTES(5)) dut5 (
      .clk(clk), .reset(reset), .start(start_s[1]), .init_en(init_s[1]), .key(key_all[39:0]),
      .mem_addr(addr_s[1]), .mem_wrdata(wd_s[1]), .mem_wren(wren_s[1]),
      .mem_rddata(rd_s[1]), .busy(busy_s[1]), .done(done_s[1]));

   rc4_ksa_engine #(.KEY_BYTES(1)) dut1 (
      .clk(clk), .reset(reset), .start(start_s[2]), .init_en(init_s[2]), .key(key_all[7:0]),
      .mem_addr(addr_s[2]), .mem_wrdata(wd_s[2]), .mem_wren(wren_s[2]),
      .mem_rddata(rd_s[2]), .busy(busy_s[2]), .done(done_s[2]));

   rc4_ksa_engine #(.KEY_BYTES(256)) dut256 (
      .clk(clk), .reset(reset), .start(start_s[3]), .init_en(init_s[3]), .key(key_all),
      .mem_addr(addr_s[3]), .mem_wrdata(wd_s[3]), .mem_wren(wren_s[3]),
      .mem_rddata(rd_s[3]), .busy(busy_s[3]), .done(done_s[3]));

   // Single-port RAMs with one-cycle read latency; pre_s loads the identity permutation.
   always @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (pre_s[n]) begin
            for (int a = 0; a < 256; a++) ram[n][a] <= 8'(a);
         end else if (wren_s[n]) begin
            ram[n][addr_s[n]] <= wd_s[n];
         end
         rd_s[n] <= ram[n][addr_s[n]];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Key index must stay below the key length whenever an engine is running.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (busy_s[0]) check("k3_range", 32'(int'(dut3.u_key_sel.k_q) < 3), 32'd1);
         if (busy_s[1]) check("k5_range", 32'(int'(dut5.u_key_sel.k_q) < 5), 32'd1);
         if (busy_s[2]) check("k1_range", 32'(int'(dut1.u_key_sel.k_q) < 1), 32'd1);
      end
   end

   task automatic randomize_key();
      for (int b = 0; b < 256; b++) key_all[8*b +: 8] = 8'($urandom);
   endtask

   task automatic check_idle_outputs(input int id, input string tag);
      check({tag, "_addr"}, 32'(addr_s[id]), 32'd0);
      check({tag, "_wrdata"}, 32'(wd_s[id]), 32'd0);
      check({tag, "_wren"}, 32'(wren_s[id]), 32'd0);
      check({tag, "_busy"}, 32'(busy_s[id]), 32'd0);
      check({tag, "_done"}, 32'(done_s[id]), 32'd0);
   endtask

   task automatic run(input int id, input bit init, input bit preload, input int disturb_at,
                      input int reset_at, input bit early, input string tag);
      int            klen;
      int            jj;
      int            wcnt;
      int            bad;
      int            delta;
      bit            got;
      bit [7:0]      kb [256];
      bit [7:0]      s  [256];
      bit [7:0]      t;
      logic [15:0]   wlog [$];
      logic [15:0]   exp_early [6];
      logic [2047:0] key_orig;

      exp_early = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0302, 16'h0203};
      klen     = KB[id];
      key_orig = key_all;
      for (int k = 0; k < klen; k++) kb[k] = key_orig[8*(klen-1-k) +: 8];
      for (int a = 0; a < 256; a++) s[a] = 8'(a);
      jj = 0;
      for (int a = 0; a < 256; a++) begin
         jj    = (jj + int'(s[a]) + int'(kb[a % klen])) % 256;
         t     = s[a];
         s[a]  = s[jj];
         s[jj] = t;
      end

      if (preload) begin
         pre_s[id] = 1'b1;
         @(posedge clk); #1;
         pre_s[id] = 1'b0;
      end
      init_s[id]  = init;
      start_s[id] = 1'b1;
      @(posedge clk); #1;
      start_s[id] = 1'b0;
      init_s[id]  = 1'($urandom_range(0, 1));
      check({tag, "_busy_after_start"}, 32'(busy_s[id]), 32'd1);

      got   = 1'b0;
      delta = -1;
      wcnt  = 0;
      for (int n = 0; n < 2500; n++) begin
         if (n > 0) begin
            @(posedge clk); #1;
         end
         if (n == reset_at) begin
            reset = 1'b0;
            #1;
            check_idle_outputs(id, {tag, "_in_reset"});
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_reset_hold_busy"}, 32'(busy_s[id]), 32'd0);
            @(negedge clk);
            reset = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check_idle_outputs(id, {tag, "_after_release"});
            return;
         end
         if (wren_s[id]) begin
            wcnt++;
            wlog.push_back({addr_s[id], wd_s[id]});
         end
         if (done_s[id]) begin
            got   = 1'b1;
            delta = n;
            break;
         end
         if (n == disturb_at) begin
            start_s[id] = 1'b1;
            randomize_key();
         end else if (n == disturb_at + 1) begin
            start_s[id] = 1'b0;
         end
      end

      check({tag, "_done_seen"}, 32'(got), 32'd1);
      check({tag, "_done_cycle"}, 32'(delta), init ? 32'd1792 : 32'd1536);
      check({tag, "_wren_cycles"}, 32'(wcnt), init ? 32'd768 : 32'd512);

      bad = 0;
      for (int a = 0; a < 256; a++) if (ram[id][a] !== s[a]) bad++;
      check({tag, "_sbox_bad_bytes"}, 32'(bad), 32'd0);

      if (init) begin
         bad = 0;
         for (int e = 0; e < 256; e++) begin
            if (wlog.size() <= e || wlog[e] !== {8'(e), 8'(e)}) bad++;
         end
         check({tag, "_init_fill_bad"}, 32'(bad), 32'd0);
      end
      if (early) begin
         for (int e = 0; e < 6; e++) begin
            check({tag, "_early_write"},
                  (wlog.size() > 256 + e) ? 32'(wlog[256 + e]) : 32'hffff_ffff,
                  32'(exp_early[e]));
         end
      end

      @(posedge clk); #1;
      check({tag, "_done_pulse_end"}, 32'(done_s[id]), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy_s[id]), 32'd0);
   endtask

   initial begin
      reset   = 1'b0;
      key_all = '0;
      for (int n = 0; n < 4; n++) begin
         start_s[n] = 1'b0;
         init_s[n]  = 1'b0;
         pre_s[n]   = 1'b0;
      end
      #2;
      check_idle_outputs(0, "reset3");
      check_idle_outputs(3, "reset256");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      key_all = '0;
      run(0, 1'b1, 1'b0, -1, -1, 1'b1, "k3_zero");

      key_all        = '0;
      key_all[23:0]  = 24'h0003ff;
      run(0, 1'b1, 1'b0, -1, -1, 1'b0, "k3_03ff");

      key_all        = '0;
      key_all[39:0]  = 40'h0102030405;
      run(1, 1'b0, 1'b1, -1, -1, 1'b0, "k5_noinit");

      randomize_key();
      run(2, 1'b1, 1'b0, -1, -1, 1'b0, "k1_rand");
      randomize_key();
      run(3, 1'b1, 1'b0, -1, -1, 1'b0, "k256_rand");
      randomize_key();
      run(3, 1'b0, 1'b1, -1, -1, 1'b0, "k256_noinit");
      randomize_key();
      run(1, 1'b1, 1'b0, -1, -1, 1'b0, "k5_rand");

      randomize_key();
      run(0, 1'b1, 1'b0, 500, -1, 1'b0, "k3_disturb");

      randomize_key();
      run(0, 1'b1, 1'b0, -1, 699, 1'b0, "k3_reset");
      randomize_key();
      run(0, 1'b1, 1'b0, -1, -1, 1'b0, "k3_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
